// File: rtl/song_recorder.sv
// song_recorder
//   Captures live key presses and writes them into one 32-entry slot of the
//   song RAM, in the same 16-bit entry format the song player reads:
//     note entry : [15]=0, [14:9]=note,       [8:3]=duration, [2:0]=0
//     rest entry : [15]=1, [14:9]=rest beats, [8:3]=0,        [2:0]=0
//   Optional feature macro: SONG_RECORDER_FILL_EN. When defined, stopping a
//   short recording pads the rest of the slot with 0x0000 entries.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   record_i       level; rise starts a recording, fall stops it
//   song_i         target slot, sampled on the record rise
//   key_note_i     pressed note, 0 = no key
//   beat_i         one-cycle beat pulse
//   wr_en_o        one-cycle RAM write strobe
//   wr_addr_o      {song, entry index}
//   wr_data_o      entry written
//   recording_o    high whenever the recorder is not idle
//   song_full_o    set once entry 31 has been written
//   entry_count_o  entries written in the current recording (0..32)
module song_recorder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        record_i,
  input  logic [1:0]  song_i,
  input  logic [5:0]  key_note_i,
  input  logic        beat_i,
  output logic        wr_en_o,
  output logic [6:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        recording_o,
  output logic        song_full_o,
  output logic [5:0]  entry_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD,
    S_REST,
    S_FINISH,
`ifdef SONG_RECORDER_FILL_EN
    S_FILL,
`endif
    S_FULL
  } state_t;

  localparam logic [5:0] MaxCount = 6'd63;

  state_t      state_q, state_d, stop_state;
  logic        record_q;
  logic [5:0]  prev_key_q;
  logic [5:0]  note_q, note_d;
  logic [5:0]  count_q, count_d;
  logic [1:0]  song_q, song_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  ecount_q, ecount_d;
  logic        full_q, full_d;
  logic        wr_en_q;
  logic [6:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic        recording_q;

  logic        rec_rise, rec_fall, key_event, last_entry, do_write;
  logic [5:0]  count_inc, note_dur, fin_dur;
  logic [15:0] entry;

  assign rec_rise   = record_i & ~record_q;
  assign rec_fall   = ~record_i & record_q;
  assign key_event  = (key_note_i != prev_key_q);
  assign last_entry = (idx_q == 5'd31);
  // Beat in the current cycle is credited to whatever is being timed now,
  // including the note/rest that a simultaneous key event ends.
  assign count_inc  = (count_q == MaxCount) ? count_q : count_q + {5'd0, beat_i};
  assign note_dur   = (count_inc == 6'd0) ? 6'd1 : count_inc;
  // In FINISH the final beat was already folded into count_q on the stop cycle.
  assign fin_dur    = (count_q == 6'd0) ? 6'd1 : count_q;

`ifdef SONG_RECORDER_FILL_EN
  assign stop_state = S_FILL;
`else
  assign stop_state = S_IDLE;
`endif

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    count_d  = count_q;
    song_d   = song_q;
    idx_d    = idx_q;
    ecount_d = ecount_q;
    full_d   = full_q;
    do_write = 1'b0;
    entry    = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (rec_rise) begin
          song_d   = song_i;
          idx_d    = 5'd0;
          ecount_d = 6'd0;
          full_d   = 1'b0;
          count_d  = 6'd0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        // Leading silence is never timed; the first pressed key starts a note.
        if (rec_fall) begin
          state_d = stop_state;
        end else if (key_note_i != 6'd0) begin
          note_d  = key_note_i;
          count_d = 6'd0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rec_fall) begin
          count_d = count_inc;
          state_d = S_FINISH;
        end else if (key_event) begin
          do_write = 1'b1;
          entry    = {1'b0, note_q, note_dur, 3'b000};
          count_d  = 6'd0;
          note_d   = key_note_i;
          if (last_entry)
            state_d = S_FULL;
          else if (key_note_i == 6'd0)
            state_d = S_REST;
        end else begin
          count_d = count_inc;
        end
      end
      S_REST: begin
        if (rec_fall) begin
          state_d = stop_state;
        end else if (key_note_i != 6'd0) begin
          count_d = 6'd0;
          note_d  = key_note_i;
          state_d = S_HOLD;
          if (count_inc != 6'd0) begin
            do_write = 1'b1;
            entry    = {1'b1, count_inc, 9'd0};
            if (last_entry)
              state_d = S_FULL;
          end
        end else if (count_inc == MaxCount) begin
          // Long silences are split into back-to-back 63-beat rests.
          do_write = 1'b1;
          entry    = {1'b1, MaxCount, 9'd0};
          count_d  = 6'd0;
          if (last_entry)
            state_d = S_FULL;
        end else begin
          count_d = count_inc;
        end
      end
      S_FINISH: begin
        do_write = 1'b1;
        entry    = {1'b0, note_q, fin_dur, 3'b000};
        state_d  = last_entry ? S_IDLE : stop_state;
      end
`ifdef SONG_RECORDER_FILL_EN
      S_FILL: begin
        do_write = 1'b1;
        entry    = 16'h0000;
        if (last_entry)
          state_d = S_IDLE;
      end
`endif
      S_FULL: begin
        if (rec_fall)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_write) begin
      idx_d    = idx_q + 5'd1;
      ecount_d = ecount_q + 6'd1;
      if (last_entry)
        full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      record_q    <= 1'b0;
      prev_key_q  <= 6'd0;
      note_q      <= 6'd0;
      count_q     <= 6'd0;
      song_q      <= 2'd0;
      idx_q       <= 5'd0;
      ecount_q    <= 6'd0;
      full_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 16'h0000;
      recording_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      record_q    <= record_i;
      prev_key_q  <= key_note_i;
      note_q      <= note_d;
      count_q     <= count_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      ecount_q    <= ecount_d;
      full_q      <= full_d;
      wr_en_q     <= do_write;
      if (do_write) begin
        wr_addr_q <= {song_q, idx_q};
        wr_data_q <= entry;
      end
      recording_q <= (state_d != S_IDLE);
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign recording_o   = recording_q;
  assign song_full_o   = full_q;
  assign entry_count_o = ecount_q;

endmodule

// File: tb/tb_song_recorder.sv
// Testbench for song_recorder: directed scenarios plus randomized recordings
// checked against a run-based model of the recording rules.
module tb_song_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        record;
  logic [1:0]  song;
  logic [5:0]  key_note;
  logic        beat;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        recording;
  logic        song_full;
  logic [5:0]  entry_count;

  int errors = 0;
  int checks = 0;

  logic [22:0] wq[$];      // observed writes {addr, data}
  logic [22:0] expq[$];    // expected writes
  logic [5:0]  tr_key[$];  // per-cycle stimulus trace of the recording
  logic        tr_beat[$];
  logic [5:0]  held_key = 6'd0;

  always #5 clk = ~clk;

  song_recorder dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .record_i      (record),
    .song_i        (song),
    .key_note_i    (key_note),
    .beat_i        (beat),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .recording_o   (recording),
    .song_full_o   (song_full),
    .entry_count_o (entry_count)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq.push_back({wr_addr, wr_data});
      $display("write addr=%02h data=%04h", wr_addr, wr_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic [5:0] k, input logic b);
    key_note = k;
    beat     = b;
    held_key = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic [5:0] k, input logic b);
    tr_key.push_back(k);
    tr_beat.push_back(b);
    cyc(k, b);
  endtask

  task automatic start_rec(input logic [1:0] s);
    wq.delete();
    tr_key.delete();
    tr_beat.delete();
    song   = s;
    record = 1'b1;
    cyc(6'd0, 1'b0);
    song   = ~s;  // must be ignored after the rise
  endtask

  task automatic stop_rec();
    int n;
    n = 0;
    record = 1'b0;
    cyc(held_key, 1'b0);
    while (recording === 1'b1 && n < 60) begin
      cyc(held_key, 1'b0);
      n++;
    end
    checks++;
    if (recording !== 1'b0) begin
      errors++;
      $display("FAIL stop_timeout: recording=%b required 0", recording);
    end
    cyc(held_key, 1'b0);
  endtask

  // Model: split the trace into runs of constant key. A run's beats are the
  // beats after its first cycle plus the beat on the first cycle of the next
  // run. Leading silence is dropped, silences become 63-beat chunks plus a
  // remainder (the remainder only if a note follows), notes clamp to 1..63.
  function automatic void build_expected(input logic [1:0] s);
    logic [15:0] ents[$];
    int n;
    int i;
    int st;
    int e;
    int beats;
    int d;
    bit last;
    logic [4:0] i5;
    n = tr_key.size();
    i = 0;
    expq.delete();
    while (i < n && tr_key[i] == 6'd0) i++;
    while (i < n) begin
      st = i;
      while (i < n && tr_key[i] == tr_key[st]) i++;
      e = i - 1;
      last = (i >= n);
      beats = 0;
      for (int j = st + 1; j <= e + 1 && j < n; j++) beats += int'(tr_beat[j]);
      if (tr_key[st] != 6'd0) begin
        d = (beats > 63) ? 63 : beats;
        if (d == 0) d = 1;
        ents.push_back({1'b0, tr_key[st], d[5:0], 3'b000});
      end else begin
        for (int c = 0; c < beats / 63; c++) ents.push_back(16'hFE00);
        if (!last && (beats % 63) != 0) ents.push_back({1'b1, 6'(beats % 63), 9'd0});
      end
    end
    while (ents.size() > 32) void'(ents.pop_back());
`ifdef SONG_RECORDER_FILL_EN
    while (ents.size() < 32) ents.push_back(16'h0000);
`endif
    for (int k = 0; k < ents.size(); k++) begin
      i5 = k[4:0];
      expq.push_back({s, i5, ents[k]});
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; record = 1'b0; song = 2'd0; key_note = 6'd0; beat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 7'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (recording !== 1'b0) begin errors++; $display("FAIL reset_recording: got %b want 0", recording); end
    checks++; if (song_full !== 1'b0) begin errors++; $display("FAIL reset_song_full: got %b want 0", song_full); end
    checks++; if (entry_count !== 6'd0) begin errors++; $display("FAIL reset_entry_count: got %0d want 0", entry_count); end
    rst_n = 1'b1;
    cyc(6'd5, 1'b1);  // key activity while idle must not record
    cyc(6'd0, 1'b0);
    checks++; if (recording !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL idle_quiet: recording=%b wr_en=%b want 0 0", recording, wr_en); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    start_rec(2'd2);
    step(6'h15, 1'b0);
    repeat (4) step(6'h15, 1'b1);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_early_write: wr_en=%b want 0", wr_en); end
    step(6'h00, 1'b0);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_note_en: got %b want 1", wr_en); end
    checks++; if (wr_addr !== 7'h40) begin errors++; $display("FAIL basic_note_addr: got %h want 40", wr_addr); end
    checks++; if (wr_data !== 16'h2A20) begin errors++; $display("FAIL basic_note_data: got %h want 2a20", wr_data); end
    checks++; if (entry_count !== 6'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", entry_count); end
    step(6'h00, 1'b1);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: wr_en=%b want 0", wr_en); end
    repeat (2) step(6'h00, 1'b1);
    step(6'h20, 1'b0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 7'h41 || wr_data !== 16'h8600) begin
      errors++; $display("FAIL basic_rest: en=%b addr=%h data=%h want 1 41 8600", wr_en, wr_addr, wr_data);
    end
    repeat (2) step(6'h20, 1'b1);
    stop_rec();
    checks++; if (wq.size() != 3) begin errors++; $display("FAIL basic_writes: got %0d want 3", wq.size()); end
    else begin
      checks++; if (wq[2] !== {7'h42, 16'h4010}) begin errors++; $display("FAIL basic_final_note: got %h want %h", wq[2], {7'h42, 16'h4010}); end
    end
    $display("test_basic done");
  endtask

  task automatic test_change_beat();
    start_rec(2'd1);
    step(6'h10, 1'b0);
    step(6'h10, 1'b1);
    step(6'h11, 1'b1);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 7'h20 || wr_data !== 16'h2010) begin
      errors++; $display("FAIL change_first: en=%b addr=%h data=%h want 1 20 2010", wr_en, wr_addr, wr_data);
    end
    step(6'h11, 1'b1);
    step(6'h00, 1'b0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 7'h21 || wr_data !== 16'h2208) begin
      errors++; $display("FAIL change_second: en=%b addr=%h data=%h want 1 21 2208", wr_en, wr_addr, wr_data);
    end
    stop_rec();
    $display("test_change_beat done");
  endtask

  task automatic test_long_rest();
    logic [22:0] want[4];
    want[0] = {7'h60, 16'h0208};
    want[1] = {7'h61, 16'hFE00};
    want[2] = {7'h62, 16'h8E00};
    want[3] = {7'h63, 16'h0408};
    start_rec(2'd3);
    step(6'd1, 1'b0);
    step(6'd1, 1'b1);
    step(6'd0, 1'b0);
    repeat (70) step(6'd0, 1'b1);
    step(6'd2, 1'b0);
    step(6'd2, 1'b1);
    step(6'd0, 1'b0);
    stop_rec();
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL long_rest_writes: got %0d want 4", wq.size()); end
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      checks++; if (wq[k] !== want[k]) begin errors++; $display("FAIL long_rest_entry%0d: got %h want %h", k, wq[k], want[k]); end
    end
    $display("test_long_rest done");
  endtask

  task automatic test_full();
    logic [5:0] k;
    logic [4:0] i5;
    start_rec(2'd0);
    for (int i = 0; i < 33; i++) begin
      k  = 6'(i + 1);
      i5 = 5'(i);
      step(k, 1'b0);
      step(6'd0, 1'b0);
      if (i < 32) begin
        checks++; if (wr_en !== 1'b1 || wr_addr !== {2'd0, i5} || wr_data !== {1'b0, k, 6'd1, 3'b000}) begin
          errors++; $display("FAIL full_note%0d: en=%b addr=%h data=%h want 1 %h %h", i, wr_en, wr_addr, wr_data, {2'd0, i5}, {1'b0, k, 6'd1, 3'b000});
        end
        checks++; if (song_full !== (i >= 31)) begin errors++; $display("FAIL full_flag%0d: got %b want %b", i, song_full, (i >= 31)); end
      end else begin
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL full_extra_write: wr_en=%b want 0", wr_en); end
        checks++; if (entry_count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d want 32", entry_count); end
      end
    end
    stop_rec();
    checks++; if (wq.size() != 32) begin errors++; $display("FAIL full_writes: got %0d want 32", wq.size()); end
    checks++; if (song_full !== 1'b1) begin errors++; $display("FAIL full_after_stop: got %b want 1", song_full); end
    $display("test_full done");
  endtask

  task automatic test_back_to_back();
    start_rec(2'd1);
    checks++; if (song_full !== 1'b0 || entry_count !== 6'd0 || recording !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: full=%b count=%0d rec=%b want 0 0 1", song_full, entry_count, recording);
    end
    step(6'd7, 1'b0);
    step(6'd0, 1'b0);
    checks++; if (wr_addr !== 7'h20 || wr_data !== 16'h0E08) begin
      errors++; $display("FAIL b2b_first: addr=%h data=%h want 20 0e08", wr_addr, wr_data);
    end
    stop_rec();
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [1:0] s;
    logic [5:0] k;
    int nseg;
    int len;
    for (int r = 0; r < 8; r++) begin
      s = 2'($urandom_range(0, 3));
      start_rec(s);
      repeat ($urandom_range(0, 3)) step(6'd0, 1'($urandom_range(0, 1)));
      nseg = (r == 7) ? 45 : $urandom_range(2, 10);
      for (int g = 0; g < nseg; g++) begin
        k   = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        len = $urandom_range(1, 6);
        for (int c = 0; c < len; c++) step(k, 1'($urandom_range(0, 1)));
      end
      stop_rec();
      build_expected(s);
      checks++; if (wq.size() != expq.size()) begin errors++; $display("FAIL rand%0d_writes: got %0d want %0d", r, wq.size(), expq.size()); end
      for (int j = 0; j < expq.size() && j < wq.size(); j++) begin
        checks++; if (wq[j] !== expq[j]) begin errors++; $display("FAIL rand%0d_entry%0d: got %h want %h", r, j, wq[j], expq[j]); end
      end
      checks++; if (entry_count !== 6'(expq.size())) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, entry_count, expq.size()); end
      checks++; if (song_full !== (expq.size() == 32)) begin errors++; $display("FAIL rand%0d_full: got %b want %b", r, song_full, (expq.size() == 32)); end
      $display("random recording %0d: song=%0d writes=%0d", r, s, wq.size());
    end
  endtask

`ifdef SONG_RECORDER_FILL_EN
  task automatic test_fill();
    logic [4:0] i5;
    start_rec(2'd1);
    step(6'd3, 1'b0);
    step(6'd3, 1'b1);
    step(6'd0, 1'b0);
    step(6'd4, 1'b0);
    step(6'd4, 1'b1);
    step(6'd0, 1'b0);
    stop_rec();
    checks++; if (wq.size() != 32) begin errors++; $display("FAIL fill_writes: got %0d want 32", wq.size()); end
    for (int j = 2; j < 32 && j < wq.size(); j++) begin
      i5 = 5'(j);
      checks++; if (wq[j] !== {2'd1, i5, 16'h0000}) begin errors++; $display("FAIL fill_entry%0d: got %h want %h", j, wq[j], {2'd1, i5, 16'h0000}); end
    end
    checks++; if (song_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", song_full); end
    // reset in the middle of filling
    start_rec(2'd2);
    step(6'd9, 1'b0);
    step(6'd0, 1'b0);
    record = 1'b0;
    repeat (4) cyc(6'd0, 1'b0);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_active: wr_en=%b want 1", wr_en); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || recording !== 1'b0) begin errors++; $display("FAIL fill_reset: wr_en=%b rec=%b want 0 0", wr_en, recording); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(6'd0, 1'b0);
    $display("test_fill done");
  endtask
`endif

  task automatic test_reset_mid();
    start_rec(2'd2);
    step(6'd9, 1'b0);
    step(6'd9, 1'b1);
    step(6'd0, 1'b0);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mid_write: wr_en=%b want 1", wr_en); end
    record = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || recording !== 1'b0 || entry_count !== 6'd0) begin
      errors++; $display("FAIL mid_reset: wr_en=%b rec=%b count=%0d want 0 0 0", wr_en, recording, entry_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6'd3, 1'b1);
    cyc(6'd0, 1'b0);
    checks++; if (wr_en !== 1'b0 || recording !== 1'b0) begin errors++; $display("FAIL mid_after: wr_en=%b rec=%b want 0 0", wr_en, recording); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change_beat();
    test_long_rest();
    test_full();
    test_back_to_back();
    test_random();
`ifdef SONG_RECORDER_FILL_EN
    test_fill();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
